// File: rtl/brick_grid_collider_if.sv
// rtl/brick_grid_collider_if.sv - control, geometry and result bundle for brick_grid_collider
// Purpose: groups the frame-check handshake, geometry snapshot inputs and
//   collision results into one bundle.
// Ports (master = frame controller, slave = collider):
//   start, load_level, level_mask          : control towards the collider
//   ball_*, paddle_*, grid_*, block_*      : geometry towards the collider
//   busy, done, hit_*, alive, blocks_left,
//   all_cleared                            : results from the collider
interface brick_grid_collider_if #(
  parameter int ROWS = 3,
  parameter int COLS = 5,
  parameter int W    = 10
);
  localparam int N     = ROWS * COLS;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

  logic             start;
  logic             load_level;
  logic [N-1:0]     level_mask;
  logic [W-1:0]     ball_x;
  logic [W-1:0]     ball_y;
  logic [W-1:0]     ball_w;
  logic [W-1:0]     ball_h;
  logic [W-1:0]     paddle_x;
  logic [W-1:0]     paddle_y;
  logic [W-1:0]     paddle_w;
  logic [W-1:0]     paddle_h;
  logic [W-1:0]     grid_x;
  logic [W-1:0]     grid_y;
  logic [W-1:0]     block_w;
  logic [W-1:0]     block_h;
  logic             busy;
  logic             done;
  logic             hit_paddle;
  logic             hit_block;
  logic [IDX_W-1:0] hit_index;
  logic             hit_side;
  logic [N-1:0]     alive;
  logic [IDX_W:0]   blocks_left;
  logic             all_cleared;

  modport master (
    output start, load_level, level_mask,
    output ball_x, ball_y, ball_w, ball_h,
    output paddle_x, paddle_y, paddle_w, paddle_h,
    output grid_x, grid_y, block_w, block_h,
    input  busy, done, hit_paddle, hit_block, hit_index, hit_side,
    input  alive, blocks_left, all_cleared
  );

  modport slave (
    input  start, load_level, level_mask,
    input  ball_x, ball_y, ball_w, ball_h,
    input  paddle_x, paddle_y, paddle_w, paddle_h,
    input  grid_x, grid_y, block_w, block_h,
    output busy, done, hit_paddle, hit_block, hit_index, hit_side,
    output alive, blocks_left, all_cleared
  );
endinterface

// File: rtl/brick_grid_collider.sv
// rtl/brick_grid_collider.sv - time-multiplexed ball/paddle/brick collision engine
// Purpose: on start, snapshots geometry, tests the paddle then each brick of a
//   ROWS x COLS grid one per clock through a single shared box comparator,
//   reports the first live brick hit and clears it from the alive mask.
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   bus      : brick_grid_collider_if slave (control, geometry, results)
module brick_grid_collider #(
  parameter int ROWS    = 3,
  parameter int COLS    = 5,
  parameter int X_PITCH = 128,
  parameter int Y_PITCH = 24,
  parameter int W       = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  brick_grid_collider_if.slave  bus
);
  localparam int N     = ROWS * COLS;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam int CLW   = (COLS > 1) ? $clog2(COLS) : 1;

  // Internal coordinate width: wide enough that origin + grid span + size
  // never wraps, so far-right bricks are only hit within their true range.
  localparam int XSPAN = (COLS - 1) * X_PITCH;
  localparam int YSPAN = (ROWS - 1) * Y_PITCH;
  localparam int SPAN  = (XSPAN > YSPAN) ? XSPAN : YSPAN;
  localparam int SPW   = $clog2(SPAN + 1);
  localparam int CW    = ((W > SPW) ? W : SPW) + 2;

  typedef enum logic [1:0] {S_IDLE, S_PADDLE, S_SCAN, S_DONE} state_t;

  state_t           state_q, state_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             hit_paddle_q, hit_paddle_d;
  logic             hit_block_q, hit_block_d;
  logic [IDX_W-1:0] hit_index_q, hit_index_d;
  logic             hit_side_q, hit_side_d;
  logic [N-1:0]     alive_q, alive_d;
  logic [IDX_W:0]   left_q, left_d;
  logic [CLW-1:0]   col_q, col_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [CW-1:0]    bx_q, bx_d;
  logic [CW-1:0]    by_q, by_d;

  // Geometry snapshot, stored as box edges.
  logic [CW-1:0]    ball_l_q, ball_l_d, ball_r_q, ball_r_d;
  logic [CW-1:0]    ball_t_q, ball_t_d, ball_b_q, ball_b_d;
  logic [CW-1:0]    pad_l_q, pad_l_d, pad_r_q, pad_r_d;
  logic [CW-1:0]    pad_t_q, pad_t_d, pad_b_q, pad_b_d;
  logic [CW-1:0]    gx_q, gx_d, gy_q, gy_d;
  logic [CW-1:0]    bw_q, bw_d, bh_q, bh_d;

  // Shared comparator: the candidate box is the paddle in PADDLE, else the brick.
  logic [CW-1:0]    cand_l, cand_r, cand_t, cand_b;
  logic [CW-1:0]    min_r, max_l, min_b, max_t, ox, oy;
  logic             overlap;
  logic             side;
  logic [IDX_W:0]   pop_cnt;

  always_comb begin
    if (state_q == S_PADDLE) begin
      cand_l = pad_l_q;
      cand_r = pad_r_q;
      cand_t = pad_t_q;
      cand_b = pad_b_q;
    end else begin
      cand_l = bx_q;
      cand_r = bx_q + bw_q;
      cand_t = by_q;
      cand_b = by_q + bh_q;
    end
    overlap = (ball_l_q < cand_r) && (ball_r_q > cand_l) &&
              (ball_t_q < cand_b) && (ball_b_q > cand_t);
    min_r = (ball_r_q < cand_r) ? ball_r_q : cand_r;
    max_l = (ball_l_q > cand_l) ? ball_l_q : cand_l;
    min_b = (ball_b_q < cand_b) ? ball_b_q : cand_b;
    max_t = (ball_t_q > cand_t) ? ball_t_q : cand_t;
    // Only meaningful when overlap is true, where both are positive.
    ox    = min_r - max_l;
    oy    = min_b - max_t;
    side  = (ox < oy);
  end

  always_comb begin
    pop_cnt = '0;
    for (int i = 0; i < N; i++) begin
      pop_cnt = pop_cnt + (IDX_W + 1)'(bus.level_mask[i]);
    end
  end

  always_comb begin
    state_d      = state_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    hit_paddle_d = hit_paddle_q;
    hit_block_d  = hit_block_q;
    hit_index_d  = hit_index_q;
    hit_side_d   = hit_side_q;
    alive_d      = alive_q;
    left_d       = left_q;
    col_d        = col_q;
    idx_d        = idx_q;
    bx_d         = bx_q;
    by_d         = by_q;
    ball_l_d     = ball_l_q;
    ball_r_d     = ball_r_q;
    ball_t_d     = ball_t_q;
    ball_b_d     = ball_b_q;
    pad_l_d      = pad_l_q;
    pad_r_d      = pad_r_q;
    pad_t_d      = pad_t_q;
    pad_b_d      = pad_b_q;
    gx_d         = gx_q;
    gy_d         = gy_q;
    bw_d         = bw_q;
    bh_d         = bh_q;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          ball_l_d     = CW'(bus.ball_x);
          ball_r_d     = CW'(bus.ball_x) + CW'(bus.ball_w);
          ball_t_d     = CW'(bus.ball_y);
          ball_b_d     = CW'(bus.ball_y) + CW'(bus.ball_h);
          pad_l_d      = CW'(bus.paddle_x);
          pad_r_d      = CW'(bus.paddle_x) + CW'(bus.paddle_w);
          pad_t_d      = CW'(bus.paddle_y);
          pad_b_d      = CW'(bus.paddle_y) + CW'(bus.paddle_h);
          gx_d         = CW'(bus.grid_x);
          gy_d         = CW'(bus.grid_y);
          bw_d         = CW'(bus.block_w);
          bh_d         = CW'(bus.block_h);
          hit_paddle_d = 1'b0;
          hit_block_d  = 1'b0;
          hit_index_d  = '0;
          hit_side_d   = 1'b0;
          busy_d       = 1'b1;
          state_d      = S_PADDLE;
        end
      end
      S_PADDLE: begin
        hit_paddle_d = overlap;
        col_d        = '0;
        idx_d        = '0;
        bx_d         = gx_q;
        by_d         = gy_q;
        state_d      = S_SCAN;
      end
      S_SCAN: begin
        if (overlap && alive_q[idx_q]) begin
          hit_block_d    = 1'b1;
          hit_index_d    = idx_q;
          hit_side_d     = side;
          alive_d[idx_q] = 1'b0;
          left_d         = left_q - 1'b1;
          busy_d         = 1'b0;
          done_d         = 1'b1;
          state_d        = S_DONE;
        end else if (idx_q == IDX_W'(N - 1)) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = S_DONE;
        end else begin
          idx_d = idx_q + 1'b1;
          // Positions are accumulated to avoid a row*pitch multiplier.
          if (col_q == CLW'(COLS - 1)) begin
            col_d = '0;
            bx_d  = gx_q;
            by_d  = by_q + CW'(Y_PITCH);
          end else begin
            col_d = col_q + 1'b1;
            bx_d  = bx_q + CW'(X_PITCH);
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase

    // Level load overrides any start or hit decided above.
    if (bus.load_level) begin
      alive_d      = bus.level_mask;
      left_d       = pop_cnt;
      state_d      = S_IDLE;
      busy_d       = 1'b0;
      done_d       = 1'b0;
      hit_paddle_d = 1'b0;
      hit_block_d  = 1'b0;
      hit_index_d  = '0;
      hit_side_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      hit_paddle_q <= 1'b0;
      hit_block_q  <= 1'b0;
      hit_index_q  <= '0;
      hit_side_q   <= 1'b0;
      alive_q      <= '1;
      left_q       <= (IDX_W + 1)'(N);
      col_q        <= '0;
      idx_q        <= '0;
      bx_q         <= '0;
      by_q         <= '0;
      ball_l_q     <= '0;
      ball_r_q     <= '0;
      ball_t_q     <= '0;
      ball_b_q     <= '0;
      pad_l_q      <= '0;
      pad_r_q      <= '0;
      pad_t_q      <= '0;
      pad_b_q      <= '0;
      gx_q         <= '0;
      gy_q         <= '0;
      bw_q         <= '0;
      bh_q         <= '0;
    end else begin
      state_q      <= state_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      hit_paddle_q <= hit_paddle_d;
      hit_block_q  <= hit_block_d;
      hit_index_q  <= hit_index_d;
      hit_side_q   <= hit_side_d;
      alive_q      <= alive_d;
      left_q       <= left_d;
      col_q        <= col_d;
      idx_q        <= idx_d;
      bx_q         <= bx_d;
      by_q         <= by_d;
      ball_l_q     <= ball_l_d;
      ball_r_q     <= ball_r_d;
      ball_t_q     <= ball_t_d;
      ball_b_q     <= ball_b_d;
      pad_l_q      <= pad_l_d;
      pad_r_q      <= pad_r_d;
      pad_t_q      <= pad_t_d;
      pad_b_q      <= pad_b_d;
      gx_q         <= gx_d;
      gy_q         <= gy_d;
      bw_q         <= bw_d;
      bh_q         <= bh_d;
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.hit_paddle  = hit_paddle_q;
  assign bus.hit_block   = hit_block_q;
  assign bus.hit_index   = hit_index_q;
  assign bus.hit_side    = hit_side_q;
  assign bus.alive       = alive_q;
  assign bus.blocks_left = left_q;
  assign bus.all_cleared = (left_q == '0);
endmodule

// File: tb/tb_brick_grid_collider.sv
// tb/tb_brick_grid_collider.sv - scoreboard bench for brick_grid_collider
module tb_brick_grid_collider;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  typedef struct {
    int          start_cyc;
    int          lat;
    logic        hp;
    logic        hb;
    logic [3:0]  idx;
    logic        side;
    logic [4:0]  left;
    logic [14:0] alive;
  } exp_t;

  exp_t q[$];

  brick_grid_collider_if bus ();

  brick_grid_collider dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every done pulse is matched against the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && bus.done) begin
      if (q.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        e = q.pop_front();
        chk("done_latency", cyc - e.start_cyc, e.lat);
        chk("hit_paddle", int'(bus.hit_paddle), int'(e.hp));
        chk("hit_block", int'(bus.hit_block), int'(e.hb));
        chk("hit_index", int'(bus.hit_index), int'(e.idx));
        chk("hit_side", int'(bus.hit_side), int'(e.side));
        chk("blocks_left", int'(bus.blocks_left), int'(e.left));
        chk("alive", int'(bus.alive), int'(e.alive));
        chk("busy_at_done", int'(bus.busy), 0);
      end
    end
  end

  task automatic load(input logic [14:0] m);
    bus.level_mask = m;
    bus.load_level = 1'b1;
    @(negedge clk);
    bus.load_level = 1'b0;
    @(negedge clk);
  endtask

  // Called at a negedge; issues one check and waits (bounded) for its done.
  task automatic check(input int x, input int y, input int lat, input logic hp,
                       input logic hb, input int idx, input logic side,
                       input int left, input logic [14:0] al);
    exp_t e;
    int   n;
    bus.ball_x = 10'(x);
    bus.ball_y = 10'(y);
    e.start_cyc = cyc;
    e.lat   = lat;
    e.hp    = hp;
    e.hb    = hb;
    e.idx   = 4'(idx);
    e.side  = side;
    e.left  = 5'(left);
    e.alive = al;
    q.push_back(e);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    // Scramble the live inputs: only the snapshot may matter.
    bus.ball_x = 10'd0;
    bus.ball_y = 10'd0;
    chk("busy_cycle1", int'(bus.busy), 1);
    n = 0;
    while (!bus.done && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!bus.done) begin
      chk("done_timeout", 0, 1);
      if (q.size() != 0) void'(q.pop_front());
    end
    @(negedge clk);
  endtask

  initial begin
    bus.start      = 1'b0;
    bus.load_level = 1'b0;
    bus.level_mask = '0;
    bus.ball_x     = 10'd0;
    bus.ball_y     = 10'd0;
    bus.ball_w     = 10'd8;
    bus.ball_h     = 10'd8;
    bus.paddle_x   = 10'd280;
    bus.paddle_y   = 10'd440;
    bus.paddle_w   = 10'd80;
    bus.paddle_h   = 10'd8;
    bus.grid_x     = 10'd0;
    bus.grid_y     = 10'd40;
    bus.block_w    = 10'd120;
    bus.block_h    = 10'd20;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    chk("rst_alive", int'(bus.alive), 32'h7FFF);
    chk("rst_blocks_left", int'(bus.blocks_left), 15);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_done", int'(bus.done), 0);
    chk("rst_all_cleared", int'(bus.all_cleared), 0);
    chk("rst_hit_block", int'(bus.hit_block), 0);

    //     x     y    lat hp hb idx sd left alive
    check(300,  300, 17, 0, 0, 0, 0, 15, 15'h7FFF);
    check(300,  436, 17, 1, 0, 0, 0, 15, 15'h7FFF);
    check(124,   50,  4, 0, 1, 1, 1, 14, 15'h7FFD);
    load(15'h7FFF);
    check(130,   50,  4, 0, 1, 1, 0, 14, 15'h7FFD);
    load(15'h7FFF);
    check(124,   58,  4, 0, 1, 1, 0, 14, 15'h7FFD);
    check(124,   58,  9, 0, 1, 6, 0, 13, 15'h7FBD);

    // Level load in the middle of a scan aborts it without a done pulse.
    bus.ball_x = 10'd300;
    bus.ball_y = 10'd300;
    bus.start  = 1'b1;
    @(negedge clk);
    bus.start  = 1'b0;
    @(negedge clk);
    @(negedge clk);
    bus.level_mask = 15'h0001;
    bus.load_level = 1'b1;
    @(negedge clk);
    bus.load_level = 1'b0;
    chk("abort_busy", int'(bus.busy), 0);
    chk("abort_blocks_left", int'(bus.blocks_left), 1);
    chk("abort_alive", int'(bus.alive), 1);
    chk("abort_hit_block", int'(bus.hit_block), 0);
    repeat (25) @(negedge clk);

    check(10,    45,  3, 0, 1, 0, 0,  0, 15'h0000);
    chk("all_cleared", int'(bus.all_cleared), 1);
    check(10,    45, 17, 0, 0, 0, 0,  0, 15'h0000);

    load(15'h7FFF);
    bus.grid_x = 10'd900;
    check(4,     50, 17, 0, 0, 0, 0, 15, 15'h7FFF);
    check(1016,  50,  3, 0, 1, 0, 1, 14, 15'h7FFE);

    repeat (3) @(negedge clk);
    chk("queue_empty", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule
